// File: rtl/debug_bank.sv
// rtl/debug_bank.sv - multi-channel Wishbone debug output bank
// Per-channel value/mask registers with set/clear writes and a shared prescaled blink phase.
module debug_bank #(
   parameter int         CHANNELS    = 2,
   parameter logic [7:0] RESET_VALUE = 8'b11011011,
   parameter int         TICK_DIV    = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_c_stb,
   input  logic                  wb_c_we,
   input  logic [7:0]            wb_c_adr,
   input  logic [7:0]            wb_c_dat,
   output logic                  wb_p_ack,
   output logic [7:0]            wb_p_dat,
   output logic [CHANNELS*8-1:0] debug
);

   localparam int            CW      = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         phase_q, phase_d;
   logic                         ack_q, ack_d;
   logic [7:0]                   dat_q, dat_d;
   logic [CHANNELS-1:0][7:0]     value_q, value_d;
   logic [CHANNELS-1:0][7:0]     mask_q, mask_d;

   logic       accept;
   logic [1:0] ch_sel;
   logic [1:0] reg_sel;
   logic [7:0] rd_data;

   assign accept  = wb_c_stb & ~ack_q;
   assign ch_sel  = wb_c_adr[3:2];
   assign reg_sel = wb_c_adr[1:0];

   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // Channels beyond CHANNELS match no loop iteration: read 0, writes dropped.
   always_comb begin
      value_d = value_q;
      mask_d  = mask_q;
      rd_data = 8'h00;
      ack_d   = accept;
      dat_d   = dat_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ch_sel == 2'(c)) begin
            rd_data = (reg_sel == 2'd3) ? mask_q[c] : value_q[c];
            if (accept && wb_c_we) begin
               case (reg_sel)
                  2'd0:    value_d[c] = wb_c_dat;
                  2'd1:    value_d[c] = value_q[c] | wb_c_dat;
                  2'd2:    value_d[c] = value_q[c] & ~wb_c_dat;
                  default: mask_d[c]  = wb_c_dat;
               endcase
            end
         end
      end
      if (accept && !wb_c_we) begin
         dat_d = rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= 8'h00;
         value_q <= {CHANNELS{RESET_VALUE}};
         mask_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         value_q <= value_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      debug = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         debug[c*8 +: 8] = value_q[c] ^ (mask_q[c] & {8{phase_q}});
      end
   end

   assign wb_p_ack = ack_q;
   assign wb_p_dat = dat_q;

endmodule

// File: tb/tb_debug_bank.sv
// tb/tb_debug_bank.sv - directed vector bench for debug_bank
// CHANNELS=2, TICK_DIV=4; inputs driven and outputs sampled on the falling edge.
module tb_debug_bank;

   logic        clk;
   logic        rst;
   logic        wb_c_stb;
   logic        wb_c_we;
   logic [7:0]  wb_c_adr;
   logic [7:0]  wb_c_dat;
   logic        wb_p_ack;
   logic [7:0]  wb_p_dat;
   logic [15:0] debug;

   int n_checks = 0;
   int n_fail   = 0;

   debug_bank #(.CHANNELS(2), .RESET_VALUE(8'hDB), .TICK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_c_stb (wb_c_stb),
      .wb_c_we  (wb_c_we),
      .wb_c_adr (wb_c_adr),
      .wb_c_dat (wb_c_dat),
      .wb_p_ack (wb_p_ack),
      .wb_p_dat (wb_p_dat),
      .debug    (debug)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference prescaler: wraps every 4 cycles, toggling phase on the wrap.
   int   m_cnt   = 0;
   logic m_phase = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         m_cnt   <= 0;
         m_phase <= 1'b0;
      end else if (m_cnt == 3) begin
         m_cnt   <= 0;
         m_phase <= ~m_phase;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [7:0]  dat;
      logic        chk_rd;
      logic [7:0]  exp_rd;
      logic [15:0] exp_dbg;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends on a falling edge; returns what was seen in the ack cycle.
   task automatic bus(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                      output logic ack, output logic [7:0] rd, output logic [15:0] dbg);
      wb_c_stb = 1'b1;
      wb_c_we  = we;
      wb_c_adr = adr;
      wb_c_dat = dat;
      @(posedge clk);
      @(negedge clk);
      ack = wb_p_ack;
      rd  = wb_p_dat;
      dbg = debug;
      wb_c_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic        ack;
   logic [7:0]  rd;
   logic [15:0] dbg;
   logic [7:0]  prev;
   logic        p0;
   int          toggles;

   initial begin
      vecs[0]  = '{1'b0, 8'h03, 8'h00, 1'b1, 8'h00, 16'hDBDB};
      vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hDB, 16'hDBDB};
      vecs[2]  = '{1'b1, 8'h04, 8'h0F, 1'b0, 8'h00, 16'h0FDB};
      vecs[3]  = '{1'b1, 8'h05, 8'hF0, 1'b0, 8'h00, 16'hFFDB};
      vecs[4]  = '{1'b1, 8'h06, 8'h3C, 1'b0, 8'h00, 16'hC3DB};
      vecs[5]  = '{1'b0, 8'h04, 8'h00, 1'b1, 8'hC3, 16'hC3DB};
      vecs[6]  = '{1'b0, 8'h05, 8'h00, 1'b1, 8'hC3, 16'hC3DB};
      vecs[7]  = '{1'b0, 8'h07, 8'h00, 1'b1, 8'h00, 16'hC3DB};
      vecs[8]  = '{1'b1, 8'h08, 8'hAA, 1'b0, 8'h00, 16'hC3DB};
      vecs[9]  = '{1'b0, 8'h08, 8'h00, 1'b1, 8'h00, 16'hC3DB};
      vecs[10] = '{1'b1, 8'h0B, 8'hFF, 1'b0, 8'h00, 16'hC3DB};
      vecs[11] = '{1'b0, 8'h0B, 8'h00, 1'b1, 8'h00, 16'hC3DB};
      vecs[12] = '{1'b0, 8'h14, 8'h00, 1'b1, 8'hC3, 16'hC3DB};
      vecs[13] = '{1'b1, 8'h12, 8'h03, 1'b0, 8'h00, 16'hC3D8};
      vecs[14] = '{1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 16'hC35A};
      vecs[15] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 16'hC35A};
      vecs[16] = '{1'b0, 8'h0C, 8'h00, 1'b1, 8'h00, 16'hC35A};

      // Reset for two cycles with a write presented that must be ignored.
      rst      = 1'b1;
      wb_c_stb = 1'b1;
      wb_c_we  = 1'b1;
      wb_c_adr = 8'h00;
      wb_c_dat = 8'h11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack", {15'b0, wb_p_ack}, 16'h0000);
      check("rst_dat", {8'h00, wb_p_dat}, 16'h0000);
      check("rst_debug", debug, 16'hDBDB);
      rst      = 1'b0;
      wb_c_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_ack", {15'b0, wb_p_ack}, 16'h0000);
      check("post_rst_debug", debug, 16'hDBDB);

      for (int i = 0; i < 17; i++) begin
         bus(vecs[i].we, vecs[i].adr, vecs[i].dat, ack, rd, dbg);
         check($sformatf("vec%0d_ack", i), {15'b0, ack}, 16'h0001);
         check($sformatf("vec%0d_debug", i), dbg, vecs[i].exp_dbg);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), {8'h00, rd}, {8'h00, vecs[i].exp_rd});
         check($sformatf("vec%0d_ack_drop", i), {15'b0, wb_p_ack}, 16'h0000);
      end

      // Held stb: only even-cycle data (0x10, 0x12, 0x14) gets committed.
      wb_c_stb = 1'b1;
      wb_c_we  = 1'b1;
      wb_c_adr = 8'h04;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("held_ack%0d", i), {15'b0, wb_p_ack}, {15'b0, i[0]});
         if (i[0]) check($sformatf("held_val%0d", i), debug, {8'h10 + 8'(i - 1), 8'h5A});
         wb_c_dat = 8'h10 + 8'(i);
         @(posedge clk);
         @(negedge clk);
      end
      check("held_ack_end", {15'b0, wb_p_ack}, 16'h0000);
      wb_c_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("held_final", debug, 16'h145A);

      // Blink ch0: value 0, mask 0x81.
      bus(1'b1, 8'h00, 8'h00, ack, rd, dbg);
      bus(1'b1, 8'h03, 8'h81, ack, rd, dbg);
      toggles = 0;
      prev    = debug[7:0];
      for (int i = 0; i < 17; i++) begin
         check($sformatf("blink%0d", i), {8'h00, debug[7:0]}, {8'h00, (m_phase ? 8'h81 : 8'h00)});
         if (debug[7:0] != prev) toggles++;
         prev = debug[7:0];
         @(negedge clk);
      end
      check("blink_toggles", 16'(toggles), 16'd4);
      bus(1'b0, 8'h03, 8'h00, ack, rd, dbg);
      check("blink_mask_rd", {8'h00, rd}, 16'h0081);
      bus(1'b1, 8'h03, 8'h00, ack, rd, dbg);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("unblink%0d", i), {8'h00, debug[7:0]}, 16'h0000);
         @(negedge clk);
      end

      // SET lands on the wrap edge: new value XOR new phase.
      bus(1'b1, 8'h03, 8'h01, ack, rd, dbg);
      for (int i = 0; i < 8 && m_cnt != 3; i++) @(negedge clk);
      check("wrap_wait", 16'(m_cnt), 16'd3);
      p0 = m_phase;
      wb_c_stb = 1'b1;
      wb_c_we  = 1'b1;
      wb_c_adr = 8'h01;
      wb_c_dat = 8'h01;
      @(posedge clk);
      @(negedge clk);
      check("collide_ack", {15'b0, wb_p_ack}, 16'h0001);
      check("collide_debug", {8'h00, debug[7:0]}, {8'h00, 8'h01 ^ {7'b0, ~p0}});
      wb_c_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset in the ack cycle of a VALUE write.
      bus(1'b1, 8'h03, 8'h00, ack, rd, dbg);
      wb_c_stb = 1'b1;
      wb_c_we  = 1'b1;
      wb_c_adr = 8'h00;
      wb_c_dat = 8'h55;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ack1", {15'b0, wb_p_ack}, 16'h0001);
      check("midrst_val", {8'h00, debug[7:0]}, 16'h0055);
      rst      = 1'b1;
      wb_c_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ack0", {15'b0, wb_p_ack}, 16'h0000);
      check("midrst_debug", debug, 16'hDBDB);
      check("midrst_cnt", 16'(dut.cnt_q), 16'd0);
      check("midrst_phase", {15'b0, dut.phase_q}, 16'h0000);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_cnt_run", 16'(dut.cnt_q), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
